// File: rtl/mips_multicycle_control_if.sv
// Datapath-facing bundle of the multi-cycle MIPS controller: IR fields and
// handshake inputs in, per-cycle control strobes and debug state out.
interface mips_multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       imm_zext;
    logic [3:0] state;
    logic       instr_done;
    logic       fault;

    // Handshake: the memory completes an access in any cycle where a strobe
    // (mem_read/mem_write) is high and mem_ready is high; the strobes and
    // iord hold steady for every cycle that mem_ready stays low.
    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, imm_zext,
               state, instr_done, fault
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_source, imm_zext,
               state, instr_done, fault
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// waits on mem_ready with an optional timeout, and parks in a sticky FAULT state.
module mips_multicycle_control #(
    parameter int MEM_TIMEOUT = 0,
    parameter bit EXT_OPS     = 1'b1
) (
    input logic                        clk,
    input logic                        reset,
    mips_multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11,
        S_FAULT  = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       imm_zext;
        logic       instr_done;
        logic       fault;
    } ctrl_t;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                           ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ   = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t          state_q, state_d;
    logic   [CW-1:0] wait_q, wait_d;
    ctrl_t           ctrl_c, ctrl_o;
    logic            r_valid, i_valid, i_zext, wait_state, timeout;
    logic   [3:0]    r_alu_op, i_alu_op;

    always_comb begin
        r_valid  = 1'b1;
        r_alu_op = ALU_ADD;
        case (bus.funct)
            6'b100000: r_alu_op = ALU_ADD;
            6'b100010: r_alu_op = ALU_SUB;
            6'b100100: r_alu_op = ALU_AND;
            6'b100101: r_alu_op = ALU_OR;
            6'b100111: r_alu_op = ALU_NOR;
            6'b101010: r_alu_op = ALU_SLT;
            default:   r_valid  = 1'b0;
        endcase
    end

    always_comb begin
        i_valid  = EXT_OPS;
        i_alu_op = ALU_ADD;
        i_zext   = 1'b0;
        case (bus.opcode)
            6'b001000: i_alu_op = ALU_ADD;
            6'b001100: begin i_alu_op = ALU_AND; i_zext = 1'b1; end
            6'b001101: begin i_alu_op = ALU_OR;  i_zext = 1'b1; end
            6'b001010: i_alu_op = ALU_SLT;
            default:   i_valid  = 1'b0;
        endcase
    end

    // Timeout fires on the cycle the counter would reach MEM_TIMEOUT; a
    // simultaneous mem_ready takes priority in the state logic below.
    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout    = (MEM_TIMEOUT != 0) && wait_state && !bus.mem_ready &&
                        ((int'(wait_q) + 1) >= MEM_TIMEOUT);

    always_comb begin
        state_d = state_q;
        ctrl_c  = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = 2'b01;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.ir_write  = bus.mem_ready;
                ctrl_c.pc_en     = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
                else if (timeout)  state_d = S_FAULT;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = 2'b11;
                ctrl_c.alu_op    = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE:     state_d = r_valid ? S_EXEC : S_FAULT;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_BNE:       state_d = EXT_OPS ? S_BRANCH : S_FAULT;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = i_valid ? S_IEXEC : S_FAULT;
                endcase
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
                ctrl_c.alu_op    = ALU_ADD;
                state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl_c.iord     = 1'b1;
                ctrl_c.mem_read = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
                else if (timeout)  state_d = S_FAULT;
            end
            S_MEMWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.instr_done = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                ctrl_c.iord       = 1'b1;
                ctrl_c.mem_write  = 1'b1;
                ctrl_c.instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
                else if (timeout)  state_d = S_FAULT;
            end
            S_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = r_alu_op;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = 1'b1;
                ctrl_c.instr_done = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a  = 1'b1;
                ctrl_c.alu_op     = ALU_SUB;
                ctrl_c.pc_source  = 2'b01;
                ctrl_c.instr_done = 1'b1;
                ctrl_c.pc_en      = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                ctrl_c.pc_source  = 2'b10;
                ctrl_c.pc_en      = 1'b1;
                ctrl_c.instr_done = 1'b1;
                state_d = S_FETCH;
            end
            S_IEXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
                ctrl_c.alu_op    = i_alu_op;
                ctrl_c.imm_zext  = i_zext;
                state_d = S_IWB;
            end
            S_IWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.instr_done = 1'b1;
                state_d = S_FETCH;
            end
            S_FAULT: ctrl_c.fault = 1'b1;
            default: state_d = S_FAULT;
        endcase
    end

    always_comb begin
        wait_d = wait_q + CW'(1);
        if (state_d != state_q || bus.mem_ready || !wait_state) wait_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs are forced low while reset is held, otherwise FETCH strobes would leak.
    assign ctrl_o         = reset ? ctrl_c : '0;
    assign bus.state      = reset ? state_q : 4'd0;
    assign bus.pc_en      = ctrl_o.pc_en;
    assign bus.iord       = ctrl_o.iord;
    assign bus.mem_read   = ctrl_o.mem_read;
    assign bus.mem_write  = ctrl_o.mem_write;
    assign bus.ir_write   = ctrl_o.ir_write;
    assign bus.reg_dst    = ctrl_o.reg_dst;
    assign bus.mem_to_reg = ctrl_o.mem_to_reg;
    assign bus.reg_write  = ctrl_o.reg_write;
    assign bus.alu_src_a  = ctrl_o.alu_src_a;
    assign bus.alu_src_b  = ctrl_o.alu_src_b;
    assign bus.alu_op     = ctrl_o.alu_op;
    assign bus.pc_source  = ctrl_o.pc_source;
    assign bus.imm_zext   = ctrl_o.imm_zext;
    assign bus.instr_done = ctrl_o.instr_done;
    assign bus.fault      = ctrl_o.fault;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: three parameterisations share one stimulus,
// expected {state, instr_done, pc_en} per cycle are queued and popped at negedge.
module tb_mips_multicycle_control;
    localparam int W = 6;
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7,
                           S_BRANCH = 4'd8, S_JUMP = 4'd9, S_IEXEC = 4'd10, S_IWB = 4'd11,
                           S_FAULT = 4'd15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    int         checks = 0;
    int         failures = 0;

    logic [W-1:0] exp_q[$];
    logic [13:0]  drv_q[$];

    logic [5:0] rfn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    logic [5:0] imm_op [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    logic [3:0] imm_alu [4] = '{4'b0010, 4'b0000, 4'b0001, 4'b0111};
    logic       imm_zx [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    mips_multicycle_control_if bus_a ();
    mips_multicycle_control_if bus_b ();
    mips_multicycle_control_if bus_c ();

    assign bus_a.opcode = opcode;  assign bus_a.funct = funct;
    assign bus_a.zero = zero;      assign bus_a.mem_ready = mem_ready;
    assign bus_b.opcode = opcode;  assign bus_b.funct = funct;
    assign bus_b.zero = zero;      assign bus_b.mem_ready = mem_ready;
    assign bus_c.opcode = opcode;  assign bus_c.funct = funct;
    assign bus_c.zero = zero;      assign bus_c.mem_ready = mem_ready;

    mips_multicycle_control #(.MEM_TIMEOUT(0), .EXT_OPS(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    mips_multicycle_control #(.MEM_TIMEOUT(0), .EXT_OPS(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    mips_multicycle_control #(.MEM_TIMEOUT(4), .EXT_OPS(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    function automatic logic [W-1:0] obs(input int which);
        case (which)
            1:       return {bus_b.state, bus_b.instr_done, bus_b.pc_en};
            2:       return {bus_c.state, bus_c.instr_done, bus_c.pc_en};
            default: return {bus_a.state, bus_a.instr_done, bus_a.pc_en};
        endcase
    endfunction

    function automatic logic [23:0] all_a();
        return {bus_a.pc_en, bus_a.iord, bus_a.mem_read, bus_a.mem_write, bus_a.ir_write,
                bus_a.reg_dst, bus_a.mem_to_reg, bus_a.reg_write, bus_a.alu_src_a,
                bus_a.alu_src_b, bus_a.alu_op, bus_a.pc_source, bus_a.imm_zext,
                bus_a.instr_done, bus_a.fault, bus_a.state};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; mem_ready = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic push_exp(input logic [3:0] s, input logic d, input logic p);
        exp_q.push_back({s, d, p});
    endtask

    task automatic push_drv(input logic mr, input logic z, input logic [5:0] op, input logic [5:0] fn);
        drv_q.push_back({mr, z, op, fn});
    endtask

    task automatic test_reset();
        logic [23:0] got;
        reset = 1'b0; mem_ready = 1'b1; opcode = 6'b100011;
        @(negedge clk);
        got = all_a();
        checks++;
        if (got !== 24'd0) begin
            failures++; $display("FAIL reset_outputs_zero got=%b exp=0", got);
        end
        checks++;
        if ({bus_c.mem_read, bus_c.fault, bus_c.state} !== 6'd0) begin
            failures++; $display("FAIL reset_c_zero got=%b exp=0", {bus_c.mem_read, bus_c.fault, bus_c.state});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_a.state, bus_a.mem_read, bus_a.iord, bus_a.fault} !== {S_FETCH, 1'b1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL first_fetch got=%b exp=%b",
                {bus_a.state, bus_a.mem_read, bus_a.iord, bus_a.fault}, {S_FETCH, 1'b1, 1'b0, 1'b0});
        end
        next_cycle();
    endtask

    task automatic test_rtype();
        logic [W-1:0] e, got;
        do_reset();
        opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
        push_exp(S_FETCH, 1'b0, 1'b1); push_exp(S_DECODE, 1'b0, 1'b0);
        push_exp(S_EXEC, 1'b0, 1'b0);  push_exp(S_ALUWB, 1'b1, 1'b0);
        push_exp(S_FETCH, 1'b0, 1'b1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            got = obs(0); e = exp_q.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL rtype_seq cyc=%0d got=%b exp=%b", n, got, e); end
            if (n == 0) begin
                checks++;
                if ({bus_a.ir_write, bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op, bus_a.pc_source} !== 10'b1_0_01_0010_00) begin
                    failures++; $display("FAIL fetch_ctrl got=%b exp=1001001000",
                        {bus_a.ir_write, bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op, bus_a.pc_source});
                end
            end
            if (n == 1) begin
                checks++;
                if ({bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op} !== 7'b0_11_0010) begin
                    failures++; $display("FAIL decode_ctrl got=%b exp=0110010", {bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op});
                end
            end
            if (n == 2) begin
                checks++;
                if ({bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op} !== 7'b1_00_0010) begin
                    failures++; $display("FAIL exec_ctrl got=%b exp=1000010", {bus_a.alu_src_a, bus_a.alu_src_b, bus_a.alu_op});
                end
            end
            if (n == 3) begin
                checks++;
                if ({bus_a.reg_write, bus_a.reg_dst, bus_a.mem_to_reg} !== 3'b110) begin
                    failures++; $display("FAIL aluwb_ctrl got=%b exp=110", {bus_a.reg_write, bus_a.reg_dst, bus_a.mem_to_reg});
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_lw_wait();
        logic [W-1:0] e, got;
        do_reset();
        opcode = 6'b100011;
        push_exp(S_FETCH, 1'b0, 1'b1); push_exp(S_DECODE, 1'b0, 1'b0); push_exp(S_MEMADR, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) push_exp(S_MEMRD, 1'b0, 1'b0);
        push_exp(S_MEMWB, 1'b1, 1'b0); push_exp(S_FETCH, 1'b0, 1'b1);
        for (int n = 0; n < 9; n++) begin
            mem_ready = !(n >= 3 && n <= 5);
            @(negedge clk);
            got = obs(0); e = exp_q.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL lw_seq cyc=%0d got=%b exp=%b", n, got, e); end
            if (n >= 3 && n <= 6) begin
                checks++;
                if ({bus_a.mem_read, bus_a.iord, bus_a.mem_write, bus_a.reg_write} !== 4'b1100) begin
                    failures++; $display("FAIL lw_wait_strobes cyc=%0d got=%b exp=1100", n,
                        {bus_a.mem_read, bus_a.iord, bus_a.mem_write, bus_a.reg_write});
                end
            end
            if (n == 7) begin
                checks++;
                if ({bus_a.reg_write, bus_a.mem_to_reg, bus_a.reg_dst} !== 3'b110) begin
                    failures++; $display("FAIL memwb_ctrl got=%b exp=110", {bus_a.reg_write, bus_a.mem_to_reg, bus_a.reg_dst});
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_sw();
        logic [W-1:0] e, got;
        do_reset();
        opcode = 6'b101011;
        push_exp(S_FETCH, 1'b0, 1'b1); push_exp(S_DECODE, 1'b0, 1'b0); push_exp(S_MEMADR, 1'b0, 1'b0);
        push_exp(S_MEMWR, 1'b0, 1'b0); push_exp(S_MEMWR, 1'b1, 1'b0); push_exp(S_FETCH, 1'b0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            mem_ready = (n != 3);
            @(negedge clk);
            got = obs(0); e = exp_q.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL sw_seq cyc=%0d got=%b exp=%b", n, got, e); end
            if (n == 3 || n == 4) begin
                checks++;
                if ({bus_a.mem_write, bus_a.iord, bus_a.mem_read, bus_a.reg_write} !== 4'b1100) begin
                    failures++; $display("FAIL memwr_strobes cyc=%0d got=%b exp=1100", n,
                        {bus_a.mem_write, bus_a.iord, bus_a.mem_read, bus_a.reg_write});
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        logic [W-1:0] e, got;
        logic is_bne, exp_pc;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            is_bne = (k >= 2);
            zero   = (k % 2 == 1);
            opcode = is_bne ? 6'b000101 : 6'b000100;
            exp_pc = is_bne ? !zero : zero;
            push_exp(S_FETCH, 1'b0, 1'b1); push_exp(S_DECODE, 1'b0, 1'b0);
            push_exp(S_BRANCH, 1'b1, exp_pc); push_exp(S_FETCH, 1'b0, 1'b1);
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                got = obs(0); e = exp_q.pop_front();
                checks++;
                if (got !== e) begin
                    failures++; $display("FAIL branch_seq bne=%0d zero=%0d cyc=%0d got=%b exp=%b", is_bne, zero, n, got, e);
                end
                if (n == 2) begin
                    checks++;
                    if ({bus_a.pc_source, bus_a.alu_op, bus_a.alu_src_a, bus_a.alu_src_b} !== 9'b01_0110_1_00) begin
                        failures++; $display("FAIL branch_ctrl got=%b exp=010110100",
                            {bus_a.pc_source, bus_a.alu_op, bus_a.alu_src_a, bus_a.alu_src_b});
                    end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_jump();
        logic [W-1:0] e, got;
        do_reset();
        opcode = 6'b000010;
        push_exp(S_FETCH, 1'b0, 1'b1); push_exp(S_DECODE, 1'b0, 1'b0);
        push_exp(S_JUMP, 1'b1, 1'b1); push_exp(S_FETCH, 1'b0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            got = obs(0); e = exp_q.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL jump_seq cyc=%0d got=%b exp=%b", n, got, e); end
            if (n == 2) begin
                checks++;
                if (bus_a.pc_source !== 2'b10) begin failures++; $display("FAIL jump_pc_source got=%b exp=10", bus_a.pc_source); end
            end
            next_cycle();
        end
    endtask

    task automatic test_imm();
        logic [W-1:0] e, got;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            opcode = imm_op[k];
            push_exp(S_FETCH, 1'b0, 1'b1); push_exp(S_DECODE, 1'b0, 1'b0); push_exp(S_IEXEC, 1'b0, 1'b0);
            push_exp(S_IWB, 1'b1, 1'b0);   push_exp(S_FETCH, 1'b0, 1'b1);
            for (int n = 0; n < 5; n++) begin
                @(negedge clk);
                got = obs(0); e = exp_q.pop_front();
                checks++;
                if (got !== e) begin failures++; $display("FAIL imm_seq op=%b cyc=%0d got=%b exp=%b", opcode, n, got, e); end
                if (n == 2) begin
                    checks++;
                    if ({bus_a.alu_op, bus_a.imm_zext, bus_a.alu_src_a, bus_a.alu_src_b} !== {imm_alu[k], imm_zx[k], 1'b1, 2'b10}) begin
                        failures++; $display("FAIL iexec_ctrl op=%b got=%b exp=%b", opcode,
                            {bus_a.alu_op, bus_a.imm_zext, bus_a.alu_src_a, bus_a.alu_src_b}, {imm_alu[k], imm_zx[k], 1'b1, 2'b10});
                    end
                end
                if (n == 3) begin
                    checks++;
                    if ({bus_a.reg_write, bus_a.reg_dst, bus_a.mem_to_reg} !== 3'b100) begin
                        failures++; $display("FAIL iwb_ctrl got=%b exp=100", {bus_a.reg_write, bus_a.reg_dst, bus_a.mem_to_reg});
                    end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] e, got;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            opcode = (k == 0) ? 6'b000000 : 6'b111111;
            funct  = 6'b000000;
            push_exp(S_FETCH, 1'b0, 1'b1); push_exp(S_DECODE, 1'b0, 1'b0);
            for (int j = 0; j < 4; j++) push_exp(S_FAULT, 1'b0, 1'b0);
            for (int n = 0; n < 6; n++) begin
                if (n >= 3) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    opcode = 6'b000010;
                end
                @(negedge clk);
                got = obs(0); e = exp_q.pop_front();
                checks++;
                if (got !== e) begin failures++; $display("FAIL illegal_seq k=%0d cyc=%0d got=%b exp=%b", k, n, got, e); end
                if (n >= 2) begin
                    checks++;
                    if ({bus_a.fault, bus_a.mem_read, bus_a.mem_write, bus_a.reg_write, bus_a.ir_write} !== 5'b10000) begin
                        failures++; $display("FAIL fault_outputs cyc=%0d got=%b exp=10000", n,
                            {bus_a.fault, bus_a.mem_read, bus_a.mem_write, bus_a.reg_write, bus_a.ir_write});
                    end
                end
                next_cycle();
            end
        end
        do_reset();
        @(negedge clk);
        checks++;
        if ({bus_a.fault, bus_a.state} !== {1'b0, S_FETCH}) begin
            failures++; $display("FAIL fault_cleared got=%b exp=00000", {bus_a.fault, bus_a.state});
        end
        next_cycle();
    endtask

    task automatic test_ext_off();
        logic [W-1:0] e, got;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            opcode = (k == 0) ? 6'b000101 : 6'b001000;
            push_exp(S_FETCH, 1'b0, 1'b1); push_exp(S_DECODE, 1'b0, 1'b0);
            push_exp(S_FAULT, 1'b0, 1'b0); push_exp(S_FAULT, 1'b0, 1'b0);
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                got = obs(1); e = exp_q.pop_front();
                checks++;
                if (got !== e) begin failures++; $display("FAIL ext_off_seq op=%b cyc=%0d got=%b exp=%b", opcode, n, got, e); end
                if (n == 3) begin
                    checks++;
                    if (bus_b.fault !== 1'b1) begin failures++; $display("FAIL ext_off_fault got=%b exp=1", bus_b.fault); end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] e, got;
        do_reset();
        opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b0;
        for (int j = 0; j < 4; j++) push_exp(S_FETCH, 1'b0, 1'b0);
        push_exp(S_FAULT, 1'b0, 1'b0); push_exp(S_FAULT, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            got = obs(2); e = exp_q.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL timeout_seq cyc=%0d got=%b exp=%b", n, got, e); end
            if (n == 5) begin
                checks++;
                if ({bus_c.fault, bus_a.state, bus_a.fault} !== {1'b1, S_FETCH, 1'b0}) begin
                    failures++; $display("FAIL timeout_fault got=%b exp=100000", {bus_c.fault, bus_a.state, bus_a.fault});
                end
            end
            next_cycle();
        end
        do_reset();
        opcode = 6'b000010;
        for (int j = 0; j < 3; j++) push_exp(S_FETCH, 1'b0, 1'b0);
        push_exp(S_FETCH, 1'b0, 1'b1); push_exp(S_DECODE, 1'b0, 1'b0);
        push_exp(S_JUMP, 1'b1, 1'b1);  push_exp(S_FETCH, 1'b0, 1'b1);
        for (int n = 0; n < 7; n++) begin
            mem_ready = (n >= 3);
            @(negedge clk);
            got = obs(2); e = exp_q.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL timeout_ready_wins cyc=%0d got=%b exp=%b", n, got, e); end
            if (n == 4) begin
                checks++;
                if (bus_c.fault !== 1'b0) begin failures++; $display("FAIL timeout_no_fault got=%b exp=0", bus_c.fault); end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] e, got;
        logic [23:0] outs;
        do_reset();
        opcode = 6'b101011;
        for (int n = 0; n < 4; n++) begin
            mem_ready = (n < 3);
            @(negedge clk);
            if (n < 3) next_cycle();
        end
        checks++;
        if ({bus_a.state, bus_a.mem_write} !== {S_MEMWR, 1'b1}) begin
            failures++; $display("FAIL mid_memwr got=%b exp=01011", {bus_a.state, bus_a.mem_write});
        end
        #1 reset = 1'b0;
        #1 outs = all_a();
        checks++;
        if (outs !== 24'd0) begin failures++; $display("FAIL mid_reset_outputs got=%b exp=0", outs); end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int j = 0; j < 3; j++) push_exp(S_FETCH, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            got = obs(0); e = exp_q.pop_front();
            checks++;
            if (got !== e || bus_a.mem_write !== 1'b0 || bus_a.mem_read !== 1'b1) begin
                failures++; $display("FAIL mid_reset_restart cyc=%0d got=%b/%b%b exp=%b/01", n, got,
                    bus_a.mem_write, bus_a.mem_read, e);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, got;
        logic [13:0] d;
        logic [5:0] op, fn;
        logic z, mr;
        int kind, wt;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            kind = $urandom_range(0, 6);
            z = 1'($urandom_range(0, 1));
            fn = rfn[$urandom_range(0, 5)];
            case (kind)
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000101;
                5: op = 6'b000010;
                default: op = imm_op[$urandom_range(0, 3)];
            endcase
            wt = $urandom_range(0, 2);
            for (int j = 0; j < wt; j++) begin push_drv(1'b0, z, op, fn); push_exp(S_FETCH, 1'b0, 1'b0); end
            push_drv(1'b1, z, op, fn); push_exp(S_FETCH, 1'b0, 1'b1);
            mr = 1'($urandom_range(0, 1));
            push_drv(mr, z, op, fn); push_exp(S_DECODE, 1'b0, 1'b0);
            case (kind)
                0: begin
                    push_drv(mr, z, op, fn); push_exp(S_EXEC, 1'b0, 1'b0);
                    push_drv(mr, z, op, fn); push_exp(S_ALUWB, 1'b1, 1'b0);
                end
                1, 2: begin
                    push_drv(mr, z, op, fn); push_exp(S_MEMADR, 1'b0, 1'b0);
                    wt = $urandom_range(0, 2);
                    for (int j = 0; j < wt; j++) begin
                        push_drv(1'b0, z, op, fn);
                        push_exp((kind == 1) ? S_MEMRD : S_MEMWR, 1'b0, 1'b0);
                    end
                    push_drv(1'b1, z, op, fn);
                    if (kind == 1) begin
                        push_exp(S_MEMRD, 1'b0, 1'b0);
                        push_drv(mr, z, op, fn); push_exp(S_MEMWB, 1'b1, 1'b0);
                    end else begin
                        push_exp(S_MEMWR, 1'b1, 1'b0);
                    end
                end
                3: begin push_drv(mr, z, op, fn); push_exp(S_BRANCH, 1'b1, z); end
                4: begin push_drv(mr, z, op, fn); push_exp(S_BRANCH, 1'b1, !z); end
                5: begin push_drv(mr, z, op, fn); push_exp(S_JUMP, 1'b1, 1'b1); end
                default: begin
                    push_drv(mr, z, op, fn); push_exp(S_IEXEC, 1'b0, 1'b0);
                    push_drv(mr, z, op, fn); push_exp(S_IWB, 1'b1, 1'b0);
                end
            endcase
        end
        push_drv(1'b0, 1'b0, 6'b000000, 6'b100000); push_exp(S_FETCH, 1'b0, 1'b0);
        while (drv_q.size() > 0) begin
            d = drv_q.pop_front();
            {mem_ready, zero, opcode, funct} = d;
            @(negedge clk);
            got = obs(0); e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++; $display("FAIL b2b_seq op=%b mr=%b got=%b exp=%b", opcode, mem_ready, got, e);
            end
            next_cycle();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jump();
        test_imm();
        test_illegal();
        test_ext_off();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
